// File: rtl/mux_scan.sv
// mux_scan: registered NCH-way display mux, manual select or auto-scan over enabled channels.
// Build option MUX_SCAN_BLANK_EN blanks the output for one cycle on every channel switch.
module mux_scan #(
   parameter int NCH   = 4,
   parameter int W     = 3,
   parameter int DWELL = 8,
   localparam int SELW = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*W-1:0]  data_in,
   input  logic [NCH-1:0]    ch_en,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic              hold,
   output logic [W-1:0]      out,
   output logic [SELW-1:0]   out_ch,
   output logic              out_valid,
   output logic              switch_pulse
);

   localparam int CW   = $clog2(DWELL) + 1;
   localparam int NPAD = 1 << SELW;
   localparam logic [NPAD-1:0] IN_RANGE = NPAD'((64'(1) << NCH) - 64'(1));

   typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [W-1:0]       out_q, out_d;
   logic [SELW-1:0]    out_ch_q, out_ch_d;
   logic               out_valid_q, out_valid_d;
   logic               switch_pulse_q, switch_pulse_d;

   // Channels padded to a power of two so any SELW-bit index is safe.
   logic [NPAD*W-1:0]  data_pad;
   logic [NPAD-1:0]    en_pad;
   logic [SELW-1:0]    next_ch;
   logic [SELW-1:0]    cand;
   logic               found;
   logic               show;

   always_comb begin
      data_pad             = '0;
      data_pad[NCH*W-1:0]  = data_in;
      en_pad               = '0;
      en_pad[NCH-1:0]      = ch_en;
   end

   // First enabled channel above out_ch_q (wrapping); stays put if none other is enabled.
   always_comb begin
      next_ch = out_ch_q;
      found   = 1'b0;
      cand    = '0;
      for (int k = 1; k < NCH; k++) begin
         cand = SELW'((int'(out_ch_q) + k) % NCH);
         if (!found && en_pad[cand]) begin
            next_ch = cand;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d  = mode ? AUTO : MANUAL;
      cnt_d    = cnt_q;
      out_ch_d = out_ch_q;
      show     = 1'b1;

      if (!mode) begin
         cnt_d = '0;
         if (IN_RANGE[sel]) out_ch_d = sel;
         else               show     = 1'b0;
      end else if (state_q == MANUAL) begin
         // Entering auto: counter restarts and no advance happens on this edge.
         cnt_d = '0;
      end else if (ch_en == '0) begin
         cnt_d = '0;
      end else if (!en_pad[out_ch_q]) begin
         out_ch_d = next_ch;
         cnt_d    = '0;
      end else if (!hold) begin
         if (cnt_q == CW'(DWELL - 1)) begin
            cnt_d    = '0;
            out_ch_d = next_ch;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      out_valid_d = show & en_pad[out_ch_d];
      out_d       = out_valid_d ? data_pad[out_ch_d*W +: W] : '0;
`ifdef MUX_SCAN_BLANK_EN
      if (out_ch_d != out_ch_q) begin
         out_valid_d = 1'b0;
         out_d       = '0;
      end
`endif
      switch_pulse_d = (out_ch_d != out_ch_q);
   end

   // NOTE: rst is sampled only at the clock edge (synchronous), and all state uses <=.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= MANUAL;
         cnt_q          <= '0;
         out_q          <= '0;
         out_ch_q       <= '0;
         out_valid_q    <= 1'b0;
         switch_pulse_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         out_q          <= out_d;
         out_ch_q       <= out_ch_d;
         out_valid_q    <= out_valid_d;
         switch_pulse_q <= switch_pulse_d;
      end
   end

   assign out          = out_q;
   assign out_ch       = out_ch_q;
   assign out_valid    = out_valid_q;
   assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan (NCH=4, W=3, DWELL=4): vector table, directed auto-scan
// sequences and a random phase, all scored against a cycle model through a queue.
`timescale 1ns/1ps
module tb_mux_scan;

   localparam int NCH   = 4;
   localparam int W     = 3;
   localparam int DWELL = 4;
   localparam int SELW  = 2;
   localparam int DW    = NCH * W;

   localparam logic [DW-1:0] D0 = {3'd6, 3'd2, 3'd3, 3'd5};
   localparam logic [DW-1:0] D1 = {3'd7, 3'd2, 3'd3, 3'd5};

   logic             clk = 1'b0;
   logic             rst;
   logic [DW-1:0]    data_in;
   logic [NCH-1:0]   ch_en;
   logic             mode;
   logic [SELW-1:0]  sel;
   logic             hold;
   logic [W-1:0]     out;
   logic [SELW-1:0]  out_ch;
   logic             out_valid;
   logic             switch_pulse;

   mux_scan #(.NCH(NCH), .W(W), .DWELL(DWELL)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .ch_en        (ch_en),
      .mode         (mode),
      .sel          (sel),
      .hold         (hold),
      .out          (out),
      .out_ch       (out_ch),
      .out_valid    (out_valid),
      .switch_pulse (switch_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]    out;
      logic [SELW-1:0] ch;
      logic            valid;
      logic            sp;
   } exp_t;

   typedef struct {
      logic            mode;
      logic [SELW-1:0] sel;
      logic [NCH-1:0]  ch_en;
      logic [DW-1:0]   data;
      exp_t            exp;
   } vec_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   logic            m_auto;
   int              m_cnt;
   logic [SELW-1:0] m_ch;
   exp_t            m_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [SELW-1:0] tb_next(input logic [SELW-1:0] cur, input logic [NCH-1:0] en);
      for (int k = 1; k < NCH; k++) begin
         int c = (int'(cur) + k) % NCH;
         if (en[c]) return SELW'(c);
      end
      return cur;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      logic [SELW-1:0] prev;
      if (!rst) begin
         m_auto = 1'b0;
         m_cnt  = 0;
         m_ch   = '0;
         m_exp  = '0;
         return;
      end
      prev = m_ch;
      if (!mode) begin
         m_cnt = 0;
         m_ch  = sel;
      end else if (!m_auto) begin
         m_cnt = 0;
      end else if (ch_en == '0) begin
         m_cnt = 0;
      end else if (!ch_en[m_ch]) begin
         m_ch  = tb_next(m_ch, ch_en);
         m_cnt = 0;
      end else if (!hold) begin
         if (m_cnt == DWELL - 1) begin
            m_cnt = 0;
            m_ch  = tb_next(m_ch, ch_en);
         end else begin
            m_cnt++;
         end
      end
      m_auto      = mode;
      m_exp.ch    = m_ch;
      m_exp.valid = ch_en[m_ch];
      m_exp.out   = ch_en[m_ch] ? data_in[m_ch*W +: W] : '0;
      m_exp.sp    = (m_ch != prev);
`ifdef MUX_SCAN_BLANK_EN
      if (m_exp.sp) begin
         m_exp.out   = '0;
         m_exp.valid = 1'b0;
      end
`endif
   endtask

   task automatic step(input bit use_vec, input exp_t vexp, input string tag);
      exp_t e;
      model_step();
      sb_q.push_back(use_vec ? vexp : m_exp);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check({tag, " out"},          32'(out),          32'(e.out));
      check({tag, " out_ch"},       32'(out_ch),       32'(e.ch));
      check({tag, " out_valid"},    32'(out_valid),    32'(e.valid));
      check({tag, " switch_pulse"}, 32'(switch_pulse), 32'(e.sp));
   endtask

   function automatic vec_t mk(input logic md, input logic [SELW-1:0] s, input logic [NCH-1:0] en,
                               input logic [DW-1:0] d, input logic [W-1:0] o,
                               input logic [SELW-1:0] c, input logic v, input logic p);
      vec_t r;
      r.mode = md; r.sel = s; r.ch_en = en; r.data = d;
      r.exp.out = o; r.exp.ch = c; r.exp.valid = v; r.exp.sp = p;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      exp_t e;
      int   ch_at[14];
      int   seen2;
      int   guard;
      logic [SELW-1:0] saved_ch;

      // Manual-mode vectors: {mode, sel, ch_en, data} -> {out, out_ch, out_valid, switch_pulse}
      vecs[0] = mk(1'b0, 2'd0, 4'b1111, D0, 3'b101, 2'd0, 1'b1, 1'b1);
      vecs[1] = mk(1'b0, 2'd0, 4'b1111, D0, 3'b101, 2'd0, 1'b1, 1'b0);
      vecs[2] = mk(1'b0, 2'd2, 4'b1111, D0, 3'b010, 2'd2, 1'b1, 1'b1);
      vecs[3] = mk(1'b0, 2'd2, 4'b1111, D0, 3'b010, 2'd2, 1'b1, 1'b0);
      vecs[4] = mk(1'b0, 2'd2, 4'b1011, D0, 3'b000, 2'd2, 1'b0, 1'b0);
      vecs[5] = mk(1'b0, 2'd1, 4'b1011, D0, 3'b011, 2'd1, 1'b1, 1'b1);
      vecs[6] = mk(1'b0, 2'd3, 4'b1011, D1, 3'b111, 2'd3, 1'b1, 1'b1);
      vecs[7] = mk(1'b0, 2'd3, 4'b1011, D1, 3'b111, 2'd3, 1'b1, 1'b0);
      vecs[8] = mk(1'b0, 2'd0, 4'b1111, D1, 3'b101, 2'd0, 1'b1, 1'b1);

      rst = 1'b0; mode = 1'b1; sel = '0; hold = 1'b0; ch_en = 4'b1111; data_in = D0;
      m_auto = 1'b0; m_cnt = 0; m_ch = '0; m_exp = '0;

      // Reset with auto requested and live data
      repeat (2) step(1'b0, '0, "reset");
      rst = 1'b1;
      step(1'b0, '0, "release");
      check("release out_ch", 32'(out_ch), 0);
      check("release out", 32'(out), 5);
      repeat (3) step(1'b0, '0, "scan0");
      check("scan0 dwell out_ch", 32'(out_ch), 0);
      step(1'b0, '0, "scan0 adv");
      check("scan0 adv out_ch", 32'(out_ch), 1);

      // Manual table
      for (int i = 0; i < 9; i++) begin
         mode = vecs[i].mode; sel = vecs[i].sel; ch_en = vecs[i].ch_en; data_in = vecs[i].data;
         e = vecs[i].exp;
`ifdef MUX_SCAN_BLANK_EN
         if (e.sp) begin
            e.out   = '0;
            e.valid = 1'b0;
         end
`endif
         step(1'b1, e, $sformatf("vec%0d", i));
      end

      // Auto scan skipping disabled ch2
      mode = 1'b1; ch_en = 4'b1011; data_in = D0; seen2 = 0;
      for (int k = 1; k <= 13; k++) begin
         step(1'b0, '0, "skip");
         ch_at[k] = int'(out_ch);
         if (out_ch == 2'd2) seen2++;
      end
      check("skip a4",  32'(ch_at[4]),  0);
      check("skip a5",  32'(ch_at[5]),  1);
      check("skip a8",  32'(ch_at[8]),  1);
      check("skip a9",  32'(ch_at[9]),  3);
      check("skip a12", 32'(ch_at[12]), 3);
      check("skip a13", 32'(ch_at[13]), 0);
      check("skip ch2 never shown", 32'(seen2), 0);

      // Hold after two dwell cycles on ch1
      repeat (4) step(1'b0, '0, "to ch1");
      check("hold start out_ch", 32'(out_ch), 1);
      step(1'b0, '0, "ch1 dwell");
      hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in[W +: W] = W'(i);
         step(1'b0, '0, "hold");
         check("hold out_ch", 32'(out_ch), 1);
      end
      hold = 1'b0;
      repeat (2) step(1'b0, '0, "post hold");
      check("post hold out_ch", 32'(out_ch), 1);
      step(1'b0, '0, "post hold adv");
      check("post hold adv out_ch", 32'(out_ch), 3);

      // Disable current channel, then all channels
      repeat (8) step(1'b0, '0, "to ch1 again");
      check("disable start out_ch", 32'(out_ch), 1);
      ch_en = 4'b1001;
      step(1'b0, '0, "drop ch1");
      check("drop ch1 out_ch", 32'(out_ch), 3);
      ch_en = 4'b0000;
      repeat (3) begin
         step(1'b0, '0, "none enabled");
         check("none out_ch", 32'(out_ch), 3);
         check("none out_valid", 32'(out_valid), 0);
      end
      ch_en = 4'b0001;
      step(1'b0, '0, "only ch0");
      check("only ch0 out_ch", 32'(out_ch), 0);
      repeat (6) step(1'b0, '0, "single channel");

      // Mode drop coinciding with dwell expiry
      ch_en = 4'b1111;
      guard = 0;
      while (m_cnt != DWELL - 1 && guard < 10) begin
         step(1'b0, '0, "align");
         guard++;
      end
      check("align reached expiry", 32'(m_cnt), DWELL - 1);
      saved_ch = m_ch;
      mode = 1'b0; sel = saved_ch;
      step(1'b0, '0, "mode vs expiry");
      check("mode vs expiry out_ch", 32'(out_ch), 32'(saved_ch));
      mode = 1'b1;
      repeat (5) step(1'b0, '0, "reenter auto");

      // Random phase
      for (int i = 0; i < 300; i++) begin
         rst     = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 11) == 0) mode = ~mode;
         hold    = ($urandom_range(0, 3) == 0);
         sel     = SELW'($urandom);
         data_in = DW'($urandom);
         if ($urandom_range(0, 7) == 0) ch_en = NCH'($urandom);
         step(1'b0, '0, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
